cloud_scheduler: RTL

//  Owns the cloud descriptor table (corner X/Y, width/height, step) and sequences per-frame motion.
//  On each FRAME_TICK it walks the table one entry per cycle, advancing X and wrapping off-screen clouds.

---
 rtl/cloud_pkg.sv | 91 +++++++++
 rtl/cloud_lfsr.sv | 22 ++
 rtl/cloud_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cloud_pkg.sv
// rtl/cloud_pkg.sv - cloud descriptor types, reset table and per-slot helpers
package cloud_pkg;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [6:0] w;
    logic [6:0] h;
    logic [3:0] step;
  } cloud_t;

  typedef enum logic [1:0] {
    SEL_X    = 2'd0,
    SEL_Y    = 2'd1,
    SEL_SIZE = 2'd2,
    SEL_STEP = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  localparam int RST_ENTRIES = 4;

  localparam cloud_t CLOUD_RST_TABLE [RST_ENTRIES] = '{
    '{x: 9'd0, y: 8'd0,   w: 7'd100, h: 7'd27, step: 4'd1},
    '{x: 9'd0, y: 8'd24,  w: 7'd39,  h: 7'd31, step: 4'd2},
    '{x: 9'd0, y: 8'd104, w: 7'd73,  h: 7'd55, step: 4'd4},
    '{x: 9'd0, y: 8'd164, w: 7'd72,  h: 7'd37, step: 4'd3}
  };

  // Slots beyond the built-in table come up empty.
  function automatic cloud_t cloud_rst_entry(input int i);
    cloud_t r;
    r = '0;
    for (int k = 0; k < RST_ENTRIES; k++) begin
      if (k == i) r = CLOUD_RST_TABLE[k];
    end
    return r;
  endfunction

  function automatic cloud_t cloud_cfg_apply(input cloud_t c, input cfg_sel_e sel,
                                             input logic [15:0] data);
    cloud_t r;
    r = c;
    case (sel)
      SEL_X:    r.x = data[8:0];
      SEL_Y:    r.y = data[7:0];
      SEL_SIZE: begin
        r.h = data[14:8];
        r.w = data[6:0];
      end
      SEL_STEP: r.step = data[3:0];
      default:  r = c;
    endcase
    return r;
  endfunction

  // Move right by step; once the left edge reaches 256+W the cloud is fully
  // off-screen and restarts at the left. >= catches steps that skip the exact value.
  function automatic cloud_t cloud_advance(input cloud_t c, input logic reseed_y,
                                           input logic [7:0] new_y);
    cloud_t     r;
    logic [8:0] nx;
    r  = c;
    nx = c.x + {5'b0, c.step};
    if (nx >= (9'd256 + {2'b0, c.w})) begin
      r.x = '0;
      if (reseed_y) r.y = new_y;
    end else begin
      r.x = nx;
    end
    return r;
  endfunction

  // Bounds widened so cx+W and cy+H never wrap.
  function automatic logic cloud_hit(input cloud_t c, input logic [15:0] coord);
    logic [9:0] qx;
    logic [9:0] qy;
    logic [9:0] x_end;
    logic [9:0] y_end;
    qx    = {2'b0, coord[7:0]};
    qy    = {2'b0, coord[15:8]};
    x_end = {1'b0, c.x} + {3'b0, c.w};
    y_end = {2'b0, c.y} + {3'b0, c.h};
    return (qy >= {2'b0, c.y}) && (qy < y_end) && (qx >= {1'b0, c.x}) && (qx < x_end);
  endfunction

endpackage

// File: rtl/cloud_lfsr.sv
// rtl/cloud_lfsr.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), built only with CLOUD_RESPAWN_RAND_EN
`ifdef CLOUD_RESPAWN_RAND_EN
module cloud_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [7:0] state
);

  // Shift left, feedback from taps 8,6,5,4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule
`endif

// File: rtl/cloud_scheduler.sv
// rtl/cloud_scheduler.sv - cloud table owner, per-frame motion walk and pixel hit test (option: CLOUD_RESPAWN_RAND_EN)
module cloud_scheduler
  import cloud_pkg::*;
#(
  parameter int         NUM_CLOUDS = 4,
  parameter int         IDX_W      = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_sel,
  input  logic [15:0]      cfg_data,
  input  logic [15:0]      cloud_coord,
  output logic [3:0]       cloud_data,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLOUDS - 1);

  cloud_t           tbl [NUM_CLOUDS];
  fsm_state_e       state;
  fsm_state_e       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [3:0]       hit_idx;
  logic             reseed_y;
  logic [7:0]       new_y;
  logic             unused;

`ifdef CLOUD_RESPAWN_RAND_EN
  logic [7:0] lfsr;

  cloud_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .state   (lfsr)
  );

  assign reseed_y = 1'b1;
  assign new_y    = {1'b0, lfsr[6:0]};
  assign unused   = ^{cfg_data[15], lfsr[7]};
`else
  assign reseed_y = 1'b0;
  assign new_y    = 8'h00;
  assign unused   = ^{cfg_data[15], LFSR_SEED};
`endif

  // Walk sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Walk next-state: one slot per cycle, then a single DONE cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (frame_tick) begin
          state_nxt = ST_WALK;
          idx_nxt   = '0;
        end
      end
      ST_WALK: begin
        if (idx == LAST_IDX) state_nxt = ST_DONE;
        else                 idx_nxt   = idx + 1'b1;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  // A tick while busy is dropped and flagged one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_overrun <= 1'b0;
    else          frame_overrun <= frame_tick && (state != ST_IDLE);
  end

  // Table: a config write to a slot pre-empts that slot's motion update this frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLOUDS; i++) tbl[i] <= cloud_rst_entry(i);
    end else begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          tbl[i] <= cloud_cfg_apply(tbl[i], cfg_sel_e'(cfg_sel), cfg_data);
        end else if ((state == ST_WALK) && (idx == IDX_W'(i))) begin
          tbl[i] <= cloud_advance(tbl[i], reseed_y, new_y);
        end
      end
    end
  end

  // Hit priority: scan high to low so the lowest hitting slot wins.
  always_comb begin
    hit_idx = 4'd0;
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (cloud_hit(tbl[i], cloud_coord)) hit_idx = 4'(i + 1);
    end
  end

  // Registered query answer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cloud_data <= 4'd0;
    else          cloud_data <= hit_idx;
  end

endmodule
